// File: rtl/irig_b_seconds_to_time_pkg.sv
// Shared IRIG-B time constants and the seconds-to-time converter state encoding.
// The BCD digit map indexes the flat digit register used by the converter.
package irig_b_seconds_to_time_pkg;

  localparam logic [31:0] SEC_PER_MIN       = 32'd60;
  localparam logic [31:0] SEC_PER_HOUR      = 32'd3600;
  localparam logic [31:0] SEC_PER_DAY       = 32'd86400;
  localparam logic [31:0] SEC_PER_YEAR      = 32'd31536000;
  localparam logic [31:0] SEC_PER_LEAP_YEAR = 32'd31622400;
  localparam logic [31:0] SEC_LIMIT_2100    = 32'd3155760000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_YEAR, ST_DAY, ST_HOUR, ST_MIN, ST_SEC, ST_DONE
  } state_t;

  // Digit slots in the working BCD register, least significant digit of each field first
  localparam int NUM_DIGITS = 10;
  localparam int D_SEC_T = 0;
  localparam int D_MIN_U = 1;
  localparam int D_MIN_T = 2;
  localparam int D_HR_U  = 3;
  localparam int D_HR_T  = 4;
  localparam int D_DAY_U = 5;
  localparam int D_DAY_T = 6;
  localparam int D_DAY_H = 7;
  localparam int D_YR_U  = 8;
  localparam int D_YR_T  = 9;
  // Set where a digit takes its carry-in from the digit below it
  localparam logic [NUM_DIGITS-1:0] CHAIN_LINK = 10'b1011010100;

endpackage

// File: rtl/irig_b_seconds_to_time_bcd_digit_inc.sv
// Single BCD digit increment with wrap 9->0 and carry-out.
module bcd_digit_inc (
  input  logic [3:0] digit,
  input  logic       inc,
  output logic [3:0] next,
  output logic       carry
);
  always_comb begin
    next  = digit;
    carry = 1'b0;
    if (inc) begin
      if (digit == 4'd9) begin
        next  = 4'd0;
        carry = 1'b1;
      end else begin
        next = digit + 4'd1;
      end
    end
  end
endmodule

// File: rtl/irig_b_seconds_to_time.sv
// Seconds-since-2000 to IRIG-B BCD time fields by iterative subtraction.
// One subtraction per cycle; BCD counters track each successful step.
module irig_b_seconds_to_time
  import irig_b_seconds_to_time_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Seconds,
  input  logic        Seconds_vld,
  output logic [6:0]  TxSecond,
  output logic [6:0]  TxMinute,
  output logic [5:0]  TxHour,
  output logic [9:0]  TxDayOfYear,
  output logic [7:0]  TxYear,
  output logic        Tx_vld,
  output logic        Busy,
  output logic        Range_err
);

  state_t state, state_nxt;
  logic [31:0] rem;
  logic [31:0] sub_len;
  logic [1:0]  leap;
  logic        start, too_big, take;

  logic [NUM_DIGITS-1:0][3:0] dig, dig_nxt;
  logic [NUM_DIGITS-1:0]      step_req, step_in, carry;

  assign too_big = Seconds >= SEC_LIMIT_2100;
  assign start   = (state == ST_IDLE) && Seconds_vld && !too_big;
  assign take    = |step_req;
  assign Busy    = (state != ST_IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sub_len   = '0;
    step_req  = '0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_YEAR;
      ST_YEAR: begin
        sub_len = (leap == 2'd0) ? SEC_PER_LEAP_YEAR : SEC_PER_YEAR;
        if (rem >= sub_len) step_req[D_YR_U] = 1'b1;
        else                state_nxt = ST_DAY;
      end
      ST_DAY: begin
        sub_len = SEC_PER_DAY;
        if (rem >= sub_len) step_req[D_DAY_U] = 1'b1;
        else                state_nxt = ST_HOUR;
      end
      ST_HOUR: begin
        sub_len = SEC_PER_HOUR;
        if (rem >= sub_len) step_req[D_HR_U] = 1'b1;
        else                state_nxt = ST_MIN;
      end
      ST_MIN: begin
        sub_len = SEC_PER_MIN;
        if (rem >= sub_len) step_req[D_MIN_U] = 1'b1;
        else                state_nxt = ST_SEC;
      end
      ST_SEC: begin
        sub_len = 32'd10;
        if (rem >= sub_len) step_req[D_SEC_T] = 1'b1;
        else                state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_base
      assign step_in[i] = step_req[i];
    end else begin : g_link
      assign step_in[i] = step_req[i] | (CHAIN_LINK[i] & carry[i-1]);
    end
    bcd_digit_inc u_inc (
      .digit (dig[i]),
      .inc   (step_in[i]),
      .next  (dig_nxt[i]),
      .carry (carry[i])
    );
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rem  <= '0;
      leap <= '0;
      dig  <= '0;
    end else if (start) begin
      rem          <= Seconds;
      leap         <= '0;
      dig          <= '0;
      dig[D_DAY_U] <= 4'd1;
    end else begin
      dig <= dig_nxt;
      if (take) rem <= rem - sub_len;
      if (step_req[D_YR_U]) leap <= leap + 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      TxSecond    <= '0;
      TxMinute    <= '0;
      TxHour      <= '0;
      TxDayOfYear <= '0;
      TxYear      <= '0;
      Tx_vld      <= 1'b0;
      Range_err   <= 1'b0;
    end else begin
      Tx_vld    <= (state == ST_DONE);
      Range_err <= (state == ST_IDLE) && Seconds_vld && too_big;
      if (state == ST_DONE) begin
        TxSecond    <= {dig[D_SEC_T][2:0], rem[3:0]};
        TxMinute    <= {dig[D_MIN_T][2:0], dig[D_MIN_U]};
        TxHour      <= {dig[D_HR_T][1:0], dig[D_HR_U]};
        TxDayOfYear <= {dig[D_DAY_H][1:0], dig[D_DAY_T], dig[D_DAY_U]};
        TxYear      <= {dig[D_YR_T], dig[D_YR_U]};
      end
    end
  end

  // Top digit bits and field-top carries cannot be reached within the valid range
  logic unused_bits;
  assign unused_bits = ^{dig[D_SEC_T][3], dig[D_MIN_T][3], dig[D_HR_T][3:2], dig[D_DAY_H][3:2],
                         carry[D_SEC_T], carry[D_MIN_T], carry[D_HR_T], carry[D_DAY_H], carry[D_YR_T]};

endmodule

// File: tb/tb_irig_b_seconds_to_time.sv
// Directed vector bench for irig_b_seconds_to_time: table of conversions plus
// hand sequences for overlapping requests and reset mid-conversion.
module tb_irig_b_seconds_to_time;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Seconds;
  logic        Seconds_vld;
  logic [6:0]  TxSecond, TxMinute;
  logic [5:0]  TxHour;
  logic [9:0]  TxDayOfYear;
  logic [7:0]  TxYear;
  logic        Tx_vld, Busy, Range_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #4 Clk = ~Clk;

  irig_b_seconds_to_time dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Seconds     (Seconds),
    .Seconds_vld (Seconds_vld),
    .TxSecond    (TxSecond),
    .TxMinute    (TxMinute),
    .TxHour      (TxHour),
    .TxDayOfYear (TxDayOfYear),
    .TxYear      (TxYear),
    .Tx_vld      (Tx_vld),
    .Busy        (Busy),
    .Range_err   (Range_err)
  );

  typedef struct {
    logic [31:0] secs;
    logic [7:0]  yr;
    logic [9:0]  doy;
    logic [5:0]  hr;
    logic [6:0]  mn;
    logic [6:0]  sc;
    int          lat;
    logic        rng;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_fields(input string tag, input vec_t v);
    check({tag, " year"}, 32'(TxYear), 32'(v.yr));
    check({tag, " day"},  32'(TxDayOfYear), 32'(v.doy));
    check({tag, " hour"}, 32'(TxHour), 32'(v.hr));
    check({tag, " min"},  32'(TxMinute), 32'(v.mn));
    check({tag, " sec"},  32'(TxSecond), 32'(v.sc));
  endtask

  task automatic request(input logic [31:0] s);
    @(negedge Clk);
    Seconds     = s;
    Seconds_vld = 1'b1;
    @(posedge Clk);
    #1 Seconds_vld = 1'b0;
  endtask

  // Fields held from the last completed conversion; range rejects must not touch them
  vec_t last;

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int lat, busy_cnt;
    tag = $sformatf("v%0d", idx);
    request(v.secs);
    if (v.rng) begin
      check({tag, " range_err"}, 32'(Range_err), 32'd1);
      check({tag, " busy"}, 32'(Busy), 32'd0);
      @(posedge Clk); #1;
      check({tag, " range_err width"}, 32'(Range_err), 32'd0);
      lat = 0;
      for (int n = 0; n < 12; n++) begin
        @(posedge Clk); #1;
        if (Tx_vld || Busy) lat++;
      end
      check({tag, " no tx/busy"}, 32'(lat), 32'd0);
      check_fields({tag, " held"}, last);
      return;
    end
    check({tag, " busy rise"}, 32'(Busy), 32'd1);
    busy_cnt = 1;
    lat = 0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge Clk); #1;
      if (Tx_vld) begin
        lat = n;
        break;
      end
      if (Busy) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    if (lat == 0) return;
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(v.lat));
    check({tag, " busy fall"}, 32'(Busy), 32'd0);
    check_fields(tag, v);
    last = v;
    @(posedge Clk); #1;
    check({tag, " tx_vld width"}, 32'(Tx_vld), 32'd0);
  endtask

  initial begin
    int txc;
    vec_t v;
    tbl[0] = '{32'd0,          8'h00, 10'h001, 6'h00, 7'h00, 7'h00, 6,   1'b0};
    tbl[1] = '{32'd31622399,   8'h00, 10'h366, 6'h23, 7'h59, 7'h59, 458, 1'b0};
    tbl[2] = '{32'd31622400,   8'h01, 10'h001, 6'h00, 7'h00, 7'h00, 7,   1'b0};
    tbl[3] = '{32'd636294896,  8'h20, 10'h060, 6'h12, 7'h34, 7'h56, 136, 1'b0};
    tbl[4] = '{32'd8553659,    8'h00, 10'h100, 6'h00, 7'h00, 7'h59, 110, 1'b0};
    tbl[5] = '{32'd3155759999, 8'h99, 10'h365, 6'h23, 7'h59, 7'h59, 556, 1'b0};
    tbl[6] = '{32'd3155760000, 8'h00, 10'h000, 6'h00, 7'h00, 7'h00, 0,   1'b1};
    tbl[7] = '{32'hFFFFFFFF,   8'h00, 10'h000, 6'h00, 7'h00, 7'h00, 0,   1'b1};

    Rst = 1'b1;
    Seconds = '0;
    Seconds_vld = 1'b0;
    last = '{32'd0, 8'h00, 10'h000, 6'h00, 7'h00, 7'h00, 0, 1'b0};
    repeat (3) @(posedge Clk);
    #1;
    check_fields("reset", last);
    check("reset tx_vld", 32'(Tx_vld), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset range_err", 32'(Range_err), 32'd0);
    @(negedge Clk) Rst = 1'b0;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Extra requests at edge 3 (mid-conversion) and edge 8 (DONE) are dropped
    v = '{32'd172805, 8'h00, 10'h003, 6'h00, 7'h00, 7'h05, 8, 1'b0};
    request(v.secs);
    txc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      Seconds     = 32'd0;
      Seconds_vld = (c == 3 || c == 8);
      @(posedge Clk); #1;
      Seconds_vld = 1'b0;
      if (Tx_vld) begin
        txc++;
        check("overlap latency", 32'(c), 32'(v.lat));
        check_fields("overlap", v);
      end
      if (c == 9) check("overlap busy after done", 32'(Busy), 32'd0);
    end
    check("overlap tx count", 32'(txc), 32'd1);

    // Reset while iterating days of a long conversion
    request(32'd31622399);
    repeat (50) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;
    #1;
    last = '{32'd0, 8'h00, 10'h000, 6'h00, 7'h00, 7'h00, 0, 1'b0};
    check_fields("rst mid", last);
    check("rst mid busy", 32'(Busy), 32'd0);
    check("rst mid tx_vld", 32'(Tx_vld), 32'd0);
    @(negedge Clk) Rst = 1'b0;
    txc = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge Clk); #1;
      if (Tx_vld || Busy) txc++;
    end
    check("rst mid no tx", 32'(txc), 32'd0);

    run_vec(tbl[3], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
